// File: rtl/traffic_light_controller.sv
// traffic_light_controller
//   Single-approach vehicle signal cycling RED -> GREEN -> YELLOW on per-phase
//   cycle timers, with an optional latched pedestrian request that inserts a
//   PED_WALK phase after RED and can cut GREEN short once MIN_GREEN has elapsed.
//
//   Build option: define TLC_PED_EN to compile in the pedestrian logic. Without
//   it the request latch is tied to 0, the button is ignored and PED_WALK is
//   unreachable (a stray 11 code falls back to RED).
//
// Ports
//   clk                in   single clock, rising edge
//   rst                in   synchronous active-high reset
//   pedestrian_button  in   debounced request level, sampled every edge
//   current_state[1:0] out  00 RED, 01 GREEN, 10 YELLOW, 11 PED_WALK
//   red/yellow/green   out  lamp drives, one-hot decode of the state register
module traffic_light_controller #(
  parameter int unsigned RED_TIME    = 6,
  parameter int unsigned GREEN_TIME  = 8,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned PED_TIME    = 5,
  parameter int unsigned MIN_GREEN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pedestrian_button,
  output logic [1:0] current_state,
  output logic       red,
  output logic       yellow,
  output logic       green
);

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_PED    = 2'b11
  } state_e;

  // Timer value seen on the final cycle of each phase.
  localparam logic [7:0] RED_LAST    = 8'(RED_TIME - 1);
  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
`ifdef TLC_PED_EN
  localparam logic [7:0] PED_LAST    = 8'(PED_TIME - 1);
`endif

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_req_q, ped_req_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RED: begin
        if (timer_q == RED_LAST) state_d = ped_req_q ? S_PED : S_GREEN;
      end
      S_GREEN: begin
        // A pending request may end GREEN once the minimum has been served.
        if (timer_q == GREEN_LAST || (ped_req_q && timer_q >= MIN_LAST))
          state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (timer_q == YELLOW_LAST) state_d = S_RED;
      end
      S_PED: begin
`ifdef TLC_PED_EN
        if (timer_q == PED_LAST) state_d = S_GREEN;
`else
        state_d = S_RED;
`endif
      end
      default: state_d = S_RED;
    endcase

    // Timer restarts at 0 on every phase change.
    timer_d = (state_d != state_q) ? 8'd0 : timer_q + 8'd1;

`ifdef TLC_PED_EN
    // Latch is forced low while walking and on the entry edge, so a press
    // coincident with PED_WALK entry is dropped rather than re-queued.
    if (state_q == S_PED || state_d == S_PED) ped_req_d = 1'b0;
    else                                      ped_req_d = ped_req_q | pedestrian_button;
`else
    ped_req_d = 1'b0;
`endif
  end

`ifndef TLC_PED_EN
  logic unused_button;
  assign unused_button = pedestrian_button;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RED;
      timer_q   <= 8'd0;
      ped_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ped_req_q <= ped_req_d;
    end
  end

  assign current_state = state_q;
  assign red           = (state_q == S_RED) || (state_q == S_PED);
  assign yellow        = (state_q == S_YELLOW);
  assign green         = (state_q == S_GREEN);

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: directed scenarios followed by random
// button/reset traffic, all checked cycle by cycle against a countdown model.
module tb_traffic_light_controller;
  localparam int RT = 6, GT = 8, YT = 3, PT = 5, MG = 2;
`ifdef TLC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] cs;
  logic       r, y, g;

  traffic_light_controller #(
    .RED_TIME(RT), .GREEN_TIME(GT), .YELLOW_TIME(YT), .PED_TIME(PT), .MIN_GREEN(MG)
  ) dut (
    .clk(clk), .rst(rst), .pedestrian_button(btn),
    .current_state(cs), .red(r), .yellow(y), .green(g)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase code, cycles left in phase (including the current one),
  // and the pending request flag.
  int ms    = 0;
  int mleft = RT;
  bit mreq  = 1'b0;

  function automatic int plen(int s);
    case (s)
      0: return RT;
      1: return GT;
      2: return YT;
      default: return PT;
    endcase
  endfunction

  task automatic model_edge(bit r_in, bit b_in);
    int nxt;
    if (r_in) begin
      ms = 0; mleft = RT; mreq = 1'b0;
      return;
    end
    nxt = ms;
    case (ms)
      0: if (mleft == 1) nxt = (PED_EN && mreq) ? 3 : 1;
      1: if (mleft == 1 || (mreq && (GT - mleft + 1) >= MG)) nxt = 2;
      2: if (mleft == 1) nxt = 0;
      default: begin
        if (!PED_EN) nxt = 0;
        else if (mleft == 1) nxt = 1;
      end
    endcase
    if (PED_EN && ms != 3 && nxt != 3) mreq = mreq | b_in;
    else mreq = 1'b0;
    if (nxt != ms) mleft = plen(nxt);
    else mleft = mleft - 1;
    ms = nxt;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check after it.
  task automatic step(bit r_in, bit b_in);
    rst = r_in;
    btn = b_in;
    @(posedge clk);
    model_edge(r_in, b_in);
    #1;
    chk("state",  {6'd0, cs}, 8'(ms));
    chk("red",    {7'd0, r},  {7'd0, (ms == 0 || ms == 3)});
    chk("yellow", {7'd0, y},  {7'd0, (ms == 2)});
    chk("green",  {7'd0, g},  {7'd0, (ms == 1)});
  endtask

  initial begin
    int n, glen, walks;

    // Reset from power-up state.
    step(1'b1, 1'b0);
    chk("rst_state", {6'd0, cs}, 8'd0);
    chk("rst_lamps", {5'd0, r, y, g}, 8'b100);

    // Free-running, no requests: two full 17-cycle rounds.
    repeat (2 * (RT + GT + YT)) step(1'b0, 1'b0);

    // Button held from the GREEN entry edge.
    step(1'b1, 1'b0);
    n = 0;
    while (!(ms == 0 && mleft == 1) && n < 40) begin step(1'b0, 1'b0); n++; end
    if (n >= 40) begin failures++; $display("FAIL held_align timeout"); end
    step(1'b0, 1'b1);
    glen = 0; n = 0;
    while (cs == 2'b01 && n < 40) begin glen++; step(1'b0, 1'b1); n++; end
    chk("green_len_held", 8'(glen), PED_EN ? 8'(MG) : 8'(GT));
    walks = 0;
    repeat (30) begin step(1'b0, 1'b0); if (cs == 2'b11) walks++; end

    // Reset mid-phase.
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("midrst_state", {6'd0, cs}, 8'd0);
    chk("midrst_lamps", {5'd0, r, y, g}, 8'b100);

    // Single pulse during RED: exactly one walk phase in the next 30 cycles.
    step(1'b0, 1'b1);
    walks = 0;
    repeat (30) begin step(1'b0, 1'b0); if (cs == 2'b11) walks++; end
    chk("walk_count", 8'(walks), PED_EN ? 8'(PT) : 8'd0);

    // Random traffic with occasional resets.
    repeat (500) step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Single-approach traffic light controller with a latched pedestrian request. It cycles a vehicle signal through RED, GREEN and YELLOW using per-state cycle timers. A pedestrian walk phase can be inserted after RED, and pending requests can shorten GREEN. It sits between a debounced pedestrian push-button input and the lamp driver outputs, and exposes its state code for status logging.

## Interface
Parameters:
- RED_TIME, 6, RED phase length in clk cycles (1..255)
- GREEN_TIME, 8, full GREEN phase length in cycles (1..255)
- YELLOW_TIME, 3, YELLOW phase length in cycles (1..255)
- PED_TIME, 5, PED_WALK phase length in cycles (1..255)
- MIN_GREEN, 2, minimum GREEN cycles before a pedestrian request may end GREEN (1..GREEN_TIME)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- pedestrian_button  input  1  request level, sampled each rising edge
- current_state  output  2  state code: 00 RED, 01 GREEN, 10 YELLOW, 11 PED_WALK
- red  output  1  vehicle red lamp
- yellow  output  1  vehicle yellow lamp
- green  output  1  vehicle green lamp

## Operation
- State register, 8-bit phase timer, 1-bit ped_req latch.
- Timer rules:
  - Timer is 0 on the edge that enters a state and increments on every edge while the state holds.
  - A timed exit occurs on the edge where the timer equals LEN-1, so each phase lasts exactly LEN cycles.
- Transitions:
  - RED -> PED_WALK if ped_req=1, else GREEN (timed).
  - GREEN -> YELLOW (timed), or early when ped_req=1 and timer >= MIN_GREEN-1.
  - YELLOW -> RED (timed).
  - PED_WALK -> GREEN (timed).
  - Code 11 reached outside the macro build -> RED next edge.
- ped_req:
  - Set when pedestrian_button=1 at an edge.
  - Cleared on the edge entering PED_WALK.
  - Held at 0 throughout PED_WALK; button presses during PED_WALK are ignored.
  - Clear on PED_WALK entry wins over a simultaneous press.
  - Multiple presses collapse into one request.
- Lamps: combinational decode of the state register, always exactly one high.
  - red=1 in RED and PED_WALK.
  - yellow=1 in YELLOW.
  - green=1 in GREEN.

## Timing
- Reset (rst=1 at an edge): state RED (00), timer 0, ped_req 0; outputs red=1, yellow=0, green=0. Reset overrides all other activity, including mid-phase and during PED_WALK.
- First edge with rst=0 starts RED timing, with timer counting from 0.
- Outputs change in the same cycle as current_state, with no extra latency.
- Button-to-effect latency:
  - A press is latched at edge k.
  - Earliest GREEN early exit is at edge k+1, subject to the MIN_GREEN rule.
- Nominal cycle with no requests: RED_TIME + GREEN_TIME + YELLOW_TIME cycles (17 with defaults).

## Configuration
- TLC_PED_EN defined:
  - Pedestrian logic compiled in as described above.
- TLC_PED_EN undefined:
  - ped_req is tied 0 and pedestrian_button is ignored.
  - PED_WALK is never entered, and GREEN always lasts GREEN_TIME.
  - Port list is unchanged.

## Test plan
Scenarios 3, 4 and 6 require TLC_PED_EN defined; scenarios 1, 2 and 5 run with or without it.
1. Assert rst one cycle from an arbitrary state -> current_state=00, red=1, yellow=0, green=0 after that edge.
2. Release reset, no button, defaults -> repeating pattern: 6 cycles 00, 8 cycles 01, 3 cycles 10; red/green/yellow one-hot throughout.
3. One-cycle button pulse during RED -> after 6 RED cycles, 5 cycles of state 11 with red=1, then GREEN; no second walk phase on the next cycle.
4. Button pulse sampled at the 5th edge of GREEN (timer=4) -> YELLOW on the next edge, GREEN lasting 5 cycles; then RED 6 cycles, then PED_WALK.
5. Button held during GREEN from its entry edge -> GREEN lasts exactly 2 cycles (MIN_GREEN). With TLC_PED_EN undefined, the same stimulus gives GREEN 8 cycles and state 11 never appears.
6. rst asserted during PED_WALK with a pending press -> state 00 and ped_req=0. The following sequence is RED 6 cycles then GREEN, with no walk phase.
